// File: rtl/regfile_writeback.sv
// Write-side controller for the 32x32 register file.
// Picks one write per cycle from the single-cycle ALU result or the head of a
// small memory-result FIFO. It also keeps a scoreboard of destinations that
// have been issued but not yet written back, which decode uses to stall.
module regfile_writeback #(
    parameter int DEPTH        = 4,  // memory-result FIFO entries, power of two, >= 2
    parameter int STARVE_LIMIT = 3   // consecutive ALU wins over a non-empty FIFO before hold
) (
    input  logic                     clock,
    input  logic                     reset,
    // decode issue
    input  logic                     issue_valid,
    input  logic [4:0]               issue_rd,
    // single-cycle ALU results
    input  logic                     alu_valid,
    input  logic [4:0]               alu_rd,
    input  logic [31:0]              alu_value,
    // memory / multi-cycle results
    input  logic                     mem_valid,
    output logic                     mem_ready,
    input  logic [4:0]               mem_rd,
    input  logic [31:0]              mem_value,
    // ALU back-pressure
    output logic                     alu_hold,
    // register file write port
    output logic [4:0]               pos,
    output logic [31:0]              writevalue,
    // decode hazard check
    input  logic [4:0]               check_rs1,
    input  logic [4:0]               check_rs2,
    output logic                     stall,
    output logic [31:0]              busy_mask,
    // status
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     err_drop
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_LIMIT) + 1;

    // FIFO storage. It has no reset: an entry is only ever read after it has
    // been written, because the occupancy count gates every pop.
    logic [4:0]    rd_mem  [DEPTH];
    logic [31:0]   val_mem [DEPTH];

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic [SW-1:0] starve_q, starve_d;
    logic          hold_q, hold_d;
    logic          err_q, err_d;

    logic [4:0]    pos_q, pos_d;
    logic [31:0]   wval_q, wval_d;

    logic [31:0]   busy_q, busy_d;

    logic          fifo_nonempty;
    logic          mem_accept;
    logic          push;
    logic          pop;
    logic          take_alu;

    assign fifo_nonempty = (count_q != '0);
    // Readiness depends on the count alone. A full FIFO refuses a new entry
    // even in a cycle that pops, so that no ready->valid combinational path exists.
    assign mem_ready     = (count_q < CW'(DEPTH));
    assign mem_accept    = mem_valid && mem_ready;
    // A result for R0 completes the handshake but is not stored.
    assign push          = mem_accept && (mem_rd != 5'd0);

    // Write-port arbitration. While hold is active, the FIFO head has priority.
    // An ALU result that arrives during hold is dropped.
    always_comb begin
        take_alu = 1'b0;
        pop      = 1'b0;
        if (hold_q) begin
            pop = fifo_nonempty;
        end else if (alu_valid) begin
            take_alu = 1'b1;
        end else begin
            pop = fifo_nonempty;
        end
    end

    // Next register-file write. Idle cycles write zero to R0.
    always_comb begin
        pos_d  = 5'd0;
        wval_d = 32'd0;
        if (pop) begin
            pos_d  = rd_mem[head_q];
            wval_d = val_mem[head_q];
        end else if (take_alu) begin
            pos_d  = alu_rd;
            wval_d = alu_value;
        end
    end

    // FIFO pointer and occupancy update. The pointers wrap naturally at DEPTH.
    always_comb begin
        head_d  = head_q + PW'(pop);
        tail_d  = tail_q + PW'(push);
        count_d = count_q + CW'(push) - CW'(pop);
    end

    // Starvation tracking. Hold is raised for exactly one cycle after the ALU
    // has beaten a waiting FIFO entry STARVE_LIMIT times in a row.
    always_comb begin
        starve_d = '0;
        hold_d   = 1'b0;
        if (take_alu && fifo_nonempty) begin
            if (starve_q == SW'(STARVE_LIMIT - 1)) begin
                hold_d = 1'b1;
            end else begin
                starve_d = starve_q + SW'(1);
            end
        end
    end

    // The dropped-result flag stays set until reset.
    always_comb begin
        err_d = err_q | (alu_valid & hold_q);
    end

    // Per-register scoreboard update. A new issue overrides the writeback
    // that completes on the same edge, because the new issue is the younger
    // producer. R0 is never marked pending.
    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_busy
            if (gi == 0) begin : g_r0
                assign busy_d[gi] = 1'b0;
            end else begin : g_rn
                logic set_bit;
                logic clr_bit;
                assign set_bit    = issue_valid && (issue_rd == 5'(gi));
                assign clr_bit    = (pos_d == 5'(gi));
                assign busy_d[gi] = set_bit | (busy_q[gi] & ~clr_bit);
            end
        end
    endgenerate

    // Store accepted memory results at the tail.
    always_ff @(posedge clock) begin
        if (push) begin
            rd_mem[tail_q]  <= mem_rd;
            val_mem[tail_q] <= mem_value;
        end
    end

    // Control and output registers. Reset discards queued results and pending bits.
    always_ff @(posedge clock) begin
        if (reset) begin
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            starve_q <= '0;
            hold_q   <= 1'b0;
            err_q    <= 1'b0;
            pos_q    <= 5'd0;
            wval_q   <= 32'd0;
            busy_q   <= 32'd0;
        end else begin
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            starve_q <= starve_d;
            hold_q   <= hold_d;
            err_q    <= err_d;
            pos_q    <= pos_d;
            wval_q   <= wval_d;
            busy_q   <= busy_d;
        end
    end

    // In the cycle when pos equals rd, the register file forwards writevalue,
    // so the cleared busy bit does not cause a hazard. Sources of R0 never stall.
    assign stall      = busy_q[check_rs1] | busy_q[check_rs2];

    assign pos        = pos_q;
    assign writevalue = wval_q;
    assign busy_mask  = busy_q;
    assign fifo_count = count_q;
    assign alu_hold   = hold_q;
    assign err_drop   = err_q;

endmodule
